// File: rtl/encode_pkg.sv
// Shared FSM encoding and step-factor helper for the encoder interpolator.
package encode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALE = 2'd3
  } state_e;

  // Fixed-point step per unit of delta: (2^ext_w - 1) / unit, truncated.
  function automatic int unsigned mult_factor(input int unsigned ext_w, input int unsigned unit);
    return ((32'd1 << ext_w) - 32'd1) / unit;
  endfunction

endpackage

// File: rtl/encode_interp_ch.sv
// One encoder channel: sample/delta capture, delta*factor step, and the
// fixed-point accumulator (modulo for wrapping channels, saturating otherwise).
module encode_interp_ch #(
  parameter int          ENCODE_WID   = 32,
  parameter int          MASK_WID     = 18,
  parameter int          EXTEND_WIDTH = 20,
  parameter int unsigned MULT_FACTOR  = 262,
  parameter bit          WRAP         = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  upd_i,
  input  logic                  have_prev_i,
  input  logic                  stale_i,
  input  logic                  run_i,
  input  logic [ENCODE_WID-1:0] sample_i,
  output logic [ENCODE_WID-1:0] pos_o,
  output logic                  wrap_o
);

  localparam int DW   = ENCODE_WID + 1;
  localparam int MFW  = $clog2(MULT_FACTOR + 1) + 1;
  localparam int SW   = DW + MFW;
  localparam int AW   = (WRAP ? MASK_WID : ENCODE_WID) + EXTEND_WIDTH;
  localparam int SUMW = ((AW > SW) ? AW : SW) + 2;

  localparam logic [ENCODE_WID-1:0] MSK  = WRAP ? ENCODE_WID'((64'd1 << MASK_WID) - 64'd1) : '1;
  localparam logic [MASK_WID-1:0]   HALF = MASK_WID'(64'd1 << (MASK_WID - 1));
  localparam logic signed [DW-1:0]  FULL = DW'(64'd1 << MASK_WID);
  localparam logic signed [MFW-1:0] MF_S = MFW'(MULT_FACTOR);
  localparam logic signed [SUMW-1:0] AMAX = SUMW'((64'sd1 <<< (AW - 1)) - 64'sd1);
  localparam logic signed [SUMW-1:0] AMIN = ~AMAX;

  logic [ENCODE_WID-1:0]  smp_in, smp_q;
  logic signed [DW-1:0]   diff, delta_d, delta_q;
  logic [MASK_WID-1:0]    dmod;
  logic signed [SW-1:0]   step_q;
  logic [AW-1:0]          acc_q, acc_nxt;
  logic signed [SUMW-1:0] acc_ext, step_ext, sum;
  logic                   upd_q, wrap_d, wrap_q;

  assign smp_in = sample_i & MSK;

  // Wrapping channels take the shortest way round the modulo circle.
  always_comb begin
    diff    = $signed({smp_in[ENCODE_WID-1], smp_in}) - $signed({smp_q[ENCODE_WID-1], smp_q});
    dmod    = diff[MASK_WID-1:0];
    delta_d = diff;
    if (WRAP) begin
      delta_d = $signed(DW'(dmod));
      if (dmod > HALF) delta_d = delta_d - FULL;
    end
  end

  always_comb begin
    acc_ext  = WRAP ? $signed(SUMW'(acc_q)) : SUMW'($signed(acc_q));
    step_ext = SUMW'(step_q);
    sum      = acc_ext + step_ext;
    wrap_d   = 1'b0;
    if (WRAP) begin
      acc_nxt = sum[AW-1:0];
      wrap_d  = !step_q[SW-1] && (|sum[SUMW-1:AW]);
    end else if (sum > AMAX) begin
      acc_nxt = AMAX[AW-1:0];
    end else if (sum < AMIN) begin
      acc_nxt = AMIN[AW-1:0];
    end else begin
      acc_nxt = sum[AW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      smp_q   <= '0;
      delta_q <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (clr_i) begin
      smp_q   <= '0;
      delta_q <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      upd_q  <= upd_i;
      wrap_q <= 1'b0;
      if (upd_i) begin
        smp_q   <= smp_in;
        delta_q <= have_prev_i ? delta_d : '0;
      end
      step_q <= stale_i ? '0 : SW'(delta_q) * SW'(MF_S);
      // A fresh sample lands exactly; stepping resumes the cycle after.
      if (upd_q) begin
        acc_q <= {smp_q[AW-EXTEND_WIDTH-1:0], {EXTEND_WIDTH{1'b0}}};
      end else if (run_i) begin
        acc_q  <= acc_nxt;
        wrap_q <= wrap_d;
      end
    end
  end

  assign pos_o  = ENCODE_WID'(acc_q[AW-1:EXTEND_WIDTH]);
  assign wrap_o = wrap_q;

endmodule

// File: rtl/encode_interp_mc.sv
// Multi-channel encoder interpolator: shared update FSM, timeout and output
// decimation around CH_NUM per-channel interpolators.
module encode_interp_mc
  import encode_pkg::*;
#(
  parameter int                CH_NUM       = 2,
  parameter int                ENCODE_WID   = 32,
  parameter int                MASK_WID     = 18,
  parameter logic [CH_NUM-1:0] WRAP_MASK    = CH_NUM'(2'b01),
  parameter int                EXTEND_WIDTH = 20,
  parameter int                UNIT_INTER   = 4000,
  parameter int                DOT          = 4,
  parameter int                GAP          = 5,
  parameter int                TIMEOUT      = 8000
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         zero_i,
  input  logic                         encode_update_i,
  input  logic [CH_NUM*ENCODE_WID-1:0] encode_i,
  output logic                         precise_en_o,
  output logic [CH_NUM*ENCODE_WID-1:0] precise_encode_o,
  output logic                         stale_o,
  output logic [CH_NUM-1:0]            wrap_o
);

  localparam int unsigned MULT_FACTOR = mult_factor(EXTEND_WIDTH, UNIT_INTER);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(GAP + 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT);
  localparam logic [DCW-1:0] GAP_LAST = DCW'(GAP - 1);
  localparam logic [DCW-1:0] DOT_V    = DCW'(DOT);

  state_e         state_q, state_d;
  logic [TW-1:0]  tmo_q;
  logic [DCW-1:0] dec_q;
  logic           en_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (encode_update_i) state_d = ST_PRIME;
      ST_PRIME: if (encode_update_i) state_d = ST_RUN;
      ST_RUN:   if (!encode_update_i && tmo_q == TMO_MAX) state_d = ST_STALE;
      ST_STALE: if (encode_update_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (zero_i) state_d = ST_IDLE;
  end

  // Timeout and decimation bookkeeping; the strobe only runs in RUN.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
      dec_q <= '0;
      en_q  <= 1'b0;
    end else begin
      if (zero_i || encode_update_i) tmo_q <= '0;
      else if (tmo_q != TMO_MAX)     tmo_q <= tmo_q + 1'b1;
      if (zero_i || state_q != ST_RUN) begin
        dec_q <= '0;
        en_q  <= 1'b0;
      end else begin
        dec_q <= (dec_q == GAP_LAST) ? '0 : dec_q + 1'b1;
        en_q  <= dec_q < DOT_V;
      end
    end
  end

  assign precise_en_o = en_q;
  assign stale_o      = state_q == ST_STALE;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    encode_interp_ch #(
      .ENCODE_WID  (ENCODE_WID),
      .MASK_WID    (MASK_WID),
      .EXTEND_WIDTH(EXTEND_WIDTH),
      .MULT_FACTOR (MULT_FACTOR),
      .WRAP        (WRAP_MASK[c])
    ) u_ch (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clr_i      (zero_i),
      .upd_i      (encode_update_i),
      .have_prev_i(state_q != ST_IDLE),
      .stale_i    (state_q == ST_STALE),
      .run_i      (state_q == ST_RUN),
      .sample_i   (encode_i[c*ENCODE_WID +: ENCODE_WID]),
      .pos_o      (precise_encode_o[c*ENCODE_WID +: ENCODE_WID]),
      .wrap_o     (wrap_o[c])
    );
  end

endmodule
